// File: rtl/xgmii_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : xgmii_decoder                                                |
// | Description : 64b/66b block decoder to 32-bit XGMII, two words per block.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module xgmii_decoder #(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_WIDTH  = 2,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [HDR_WIDTH-1:0]  i_rx_sync_hdr,
    input  logic                  i_rx_data_valid,
    output logic [DATA_WIDTH-1:0] o_xgmii_rxd,
    output logic [CTRL_WIDTH-1:0] o_xgmii_rxc,
    output logic                  o_xgmii_valid,
    output logic                  o_decoding_err
);

    localparam logic [DATA_WIDTH-1:0] c_idle_word = {CTRL_WIDTH{8'h07}};
    localparam logic [DATA_WIDTH-1:0] c_err_word  = {CTRL_WIDTH{8'hFE}};
    localparam logic [CTRL_WIDTH-1:0] c_all_ctrl  = {CTRL_WIDTH{1'b1}};

    typedef enum logic [1:0] {RX_C = 2'd0, RX_D = 2'd1, RX_E = 2'd2} rx_state_t;
    typedef enum logic [2:0] {BLK_C, BLK_S, BLK_D, BLK_T, BLK_E} blk_class_t;

    rx_state_t               state_q, state_d, w_fsm_next;
    logic                    phase_q, phase_d;
    logic [DATA_WIDTH-1:0]   w0_q, w0_d;
    logic [HDR_WIDTH-1:0]    hdr_q, hdr_d;
    logic                    pend_q, pend_d;
    logic [DATA_WIDTH-1:0]   pend_rxd_q, pend_rxd_d;
    logic [CTRL_WIDTH-1:0]   pend_rxc_q, pend_rxc_d;
    logic [DATA_WIDTH-1:0]   rxd_q, rxd_d;
    logic [CTRL_WIDTH-1:0]   rxc_q, rxc_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;

    logic [2*DATA_WIDTH-1:0] w_blk;
    logic [7:0]              w_lane [8];
    logic [7:0]              w_ctl;
    logic [6:0]              w_code;
    logic [2:0]              w_term_pos;
    logic                    w_is_term;
    blk_class_t              w_cls;
    logic                    w_accept_w1;
    logic                    w_blk_err;
    logic [DATA_WIDTH-1:0]   w_lo_rxd, w_hi_rxd;

    assign w_accept_w1 = i_rx_data_valid & phase_q;

    // Block decode: the current input word is W1, the registered word is W0.
    always_comb begin
        w_blk      = {i_rx_data, w0_q};
        w_ctl      = 8'hFF;
        w_cls      = BLK_E;
        w_code     = 7'h00;
        w_term_pos = 3'd0;
        w_is_term  = 1'b1;
        for (int i = 0; i < 8; i++) w_lane[i] = 8'h07;

        case (w0_q[7:0])
            8'h87:   w_term_pos = 3'd0;
            8'h99:   w_term_pos = 3'd1;
            8'hAA:   w_term_pos = 3'd2;
            8'hB4:   w_term_pos = 3'd3;
            8'hCC:   w_term_pos = 3'd4;
            8'hD2:   w_term_pos = 3'd5;
            8'hE1:   w_term_pos = 3'd6;
            8'hFF:   w_term_pos = 3'd7;
            default: w_is_term  = 1'b0;
        endcase

        if (hdr_q == 2'b01) begin
            w_cls = BLK_D;
            w_ctl = 8'h00;
            for (int i = 0; i < 8; i++) w_lane[i] = w_blk[8*i +: 8];
        end else if (hdr_q == 2'b10) begin
            if (w0_q[7:0] == 8'h1E) begin
                w_cls = BLK_C;
                for (int i = 0; i < 8; i++) begin
                    w_code = w_blk[8 + 7*i +: 7];
                    if (w_code != 7'h00) begin
                        w_lane[i] = 8'hFE;
                        if (w_code != 7'h1E) w_cls = BLK_E;
                    end
                end
            end else if (w0_q[7:0] == 8'h78) begin
                w_cls     = BLK_S;
                w_ctl     = 8'h01;
                w_lane[0] = 8'hFB;
                for (int i = 1; i < 8; i++) w_lane[i] = w_blk[8*i +: 8];
            end else if (w0_q[7:0] == 8'h33) begin
                w_cls     = BLK_S;
                w_ctl     = 8'h1F;
                w_lane[4] = 8'hFB;
                for (int i = 5; i < 8; i++) w_lane[i] = w_blk[8*i +: 8];
            end else if (w_is_term) begin
                w_cls = BLK_T;
                // Data ahead of T comes from block bytes 1..T, shifted down one lane.
                for (int j = 1; j < 8; j++) begin
                    if (j - 1 < int'(w_term_pos)) begin
                        w_lane[j-1]  = w_blk[8*j +: 8];
                        w_ctl[j-1]   = 1'b0;
                    end
                end
                w_lane[w_term_pos] = 8'hFD;
            end
        end

        w_lo_rxd = '0;
        w_hi_rxd = '0;
        for (int i = 0; i < 4; i++) begin
            w_lo_rxd[8*i +: 8] = w_lane[i];
            w_hi_rxd[8*i +: 8] = w_lane[i+4];
        end
    end

    // Receive sequence FSM; any block that lands in RX_E is reported as an error.
    always_comb begin
        w_fsm_next = RX_E;
        case (state_q)
            RX_C: begin
                if (w_cls == BLK_C)      w_fsm_next = RX_C;
                else if (w_cls == BLK_S) w_fsm_next = RX_D;
            end
            RX_D: begin
                if (w_cls == BLK_D)      w_fsm_next = RX_D;
                else if (w_cls == BLK_T) w_fsm_next = RX_C;
            end
            default: begin
                if (w_cls == BLK_C)      w_fsm_next = RX_C;
                else if (w_cls == BLK_S) w_fsm_next = RX_D;
            end
        endcase
        w_blk_err = (w_fsm_next == RX_E);
        state_d   = w_accept_w1 ? w_fsm_next : state_q;
    end

    always_comb begin
        phase_d    = phase_q;
        w0_d       = w0_q;
        hdr_d      = hdr_q;
        pend_d     = pend_q;
        pend_rxd_d = pend_rxd_q;
        pend_rxc_d = pend_rxc_q;
        rxd_d      = c_idle_word;
        rxc_d      = c_all_ctrl;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (i_rx_data_valid) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                w0_d  = i_rx_data;
                hdr_d = i_rx_sync_hdr;
            end
        end

        if (w_accept_w1) begin
            valid_d = 1'b1;
            err_d   = w_blk_err;
            pend_d  = 1'b1;
            if (w_blk_err) begin
                rxd_d      = c_err_word;
                rxc_d      = c_all_ctrl;
                pend_rxd_d = c_err_word;
                pend_rxc_d = c_all_ctrl;
            end else begin
                rxd_d      = w_lo_rxd;
                rxc_d      = w_ctl[3:0];
                pend_rxd_d = w_hi_rxd;
                pend_rxc_d = w_ctl[7:4];
            end
        end else if (pend_q) begin
            valid_d = 1'b1;
            rxd_d   = pend_rxd_q;
            rxc_d   = pend_rxc_q;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= RX_C;
            phase_q    <= 1'b0;
            w0_q       <= '0;
            hdr_q      <= '0;
            pend_q     <= 1'b0;
            pend_rxd_q <= c_idle_word;
            pend_rxc_q <= c_all_ctrl;
            rxd_q      <= c_idle_word;
            rxc_q      <= c_all_ctrl;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            w0_q       <= w0_d;
            hdr_q      <= hdr_d;
            pend_q     <= pend_d;
            pend_rxd_q <= pend_rxd_d;
            pend_rxc_q <= pend_rxc_d;
            rxd_q      <= rxd_d;
            rxc_q      <= rxc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign o_xgmii_rxd    = rxd_q;
    assign o_xgmii_rxc    = rxc_q;
    assign o_xgmii_valid  = valid_q;
    assign o_decoding_err = err_q;

endmodule
`default_nettype wire

// File: doc/xgmii_decoder.md
XGMII_DECODER -- requirements
Module: xgmii_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning input/output word width in bits.
REQ-002 SHALL have parameter HDR_WIDTH, default 2, meaning sync header width.
REQ-003 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, meaning XGMII control bits per word.
REQ-004 SHALL have port i_clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_reset_n, input, 1, meaning reset; it is synchronous and active-low.
REQ-006 SHALL have port i_rx_data, input, DATA_WIDTH, meaning descrambled block half-word; the first word of a block carries byte0/block type in [7:0].
REQ-007 SHALL have port i_rx_sync_hdr, input, HDR_WIDTH, meaning the block sync header, sampled with the first word only.
REQ-008 SHALL have port i_rx_data_valid, input, 1, meaning i_rx_data and i_rx_sync_hdr are valid this cycle.
REQ-009 SHALL have port o_xgmii_rxd, output, DATA_WIDTH, meaning XGMII data for lanes 0-3 or 4-7.
REQ-010 SHALL have port o_xgmii_rxc, output, CTRL_WIDTH, meaning XGMII control bits; bit n is set when byte n is control.
REQ-011 SHALL have port o_xgmii_valid, output, 1, meaning o_xgmii_rxd/o_xgmii_rxc are valid this cycle.
REQ-012 SHALL have port o_decoding_err, output, 1, meaning a one-cycle pulse per erroneous block.

Function
REQ-013 SHALL keep a phase bit that toggles only on i_rx_data_valid; phase 0 = first word (W0), phase 1 = second word (W1).
REQ-014 SHALL register W0 and its header on phase 0; the block decodes when W1 is accepted (cycle N).
REQ-015 SHALL output lanes 0-3 at N+1 and lanes 4-7 at N+2, each with o_xgmii_valid=1, holding decoded lanes 4-7 in a register.
REQ-016 SHALL sustain back-to-back valid words with no output gaps; gaps on input produce matching output gaps.
REQ-017 SHALL decode header 2'b01 as data: rxd = W0 at N+1, W1 at N+2, rxc=4'h0 for both.
REQ-018 SHALL decode header 2'b10 with type 0x1E as eight 7-bit codes: 0x00->0x07, 0x1E->0xFE, any other code->0xFE plus an error; rxc=4'hF.
REQ-019 SHALL decode type 0x78 as S0=0xFB, D1-D7 from bytes 1-7, rxc=0001 then 0000.
REQ-020 SHALL decode type 0x33 as lanes 0-3=0x07, lane4=0xFB, D5-D7, rxc=1111 then 0001.
REQ-021 SHALL decode types 0x87/99/AA/B4/CC/D2/E1/FF as terminate in lane 0-7 respectively: data bytes precede, taken in order from byte1 upward; T=0xFD; lanes after T=0x07; rxc set for T and following lanes.
REQ-022 SHALL treat header 2'b00/2'b11 or any other block type as an error block.
REQ-023 SHALL run the receive sequence FSM, updated at cycle N, with states RX_C (control), RX_D (in frame), and RX_E (error).
REQ-024 SHALL transition RX_C: ctrl/idle->RX_C; start->RX_D; data, terminate, or error->RX_E.
REQ-025 SHALL transition RX_D: data->RX_D; terminate->RX_C; start, ctrl, or error->RX_E.
REQ-026 SHALL transition RX_E: ctrl->RX_C; start->RX_D; otherwise stay in RX_E.
REQ-027 SHALL, for any block judged erroneous (decode or FSM), replace both words with rxd=0xFEFEFEFE, rxc=4'hF, and pulse o_decoding_err for one cycle at N+1.
REQ-028 SHALL output rxd=0x07070707, rxc=4'hF, valid=0 when no word is emitted.

Reset
REQ-029 SHALL, on reset, set phase=0, FSM=RX_C, o_xgmii_valid=0, o_decoding_err=0, o_xgmii_rxd=0x07070707, o_xgmii_rxc=4'hF.
REQ-030 SHALL discard any partially received block or pending lanes 4-7 word on reset asserted mid-operation, with no output until a new W0/W1 pair.

Verification
REQ-031 SHALL be verified by this scenario: hdr 10, W0=0x0000001E, W1=0 -> two words 0x07070707/rxc F, err=0.
REQ-032 SHALL be verified by this scenario: start 0x78 (W0=0x5555551E... W0=0x55555578, W1=0x55555555), then data blocks, then 0x87 -> 0x555555FB/1, 0x55555555/0, ..., 0x070707FD/F, 0x07070707/F.
REQ-033 SHALL be verified by this scenario: idle then 0x33 then data, then 0xCC (W0=0xDDCCBBCC... D0-D2 at bytes1-3, W1 D3 at byte0) -> lane4=0xFB, terminate at lane4, rxc=0000 then 1111.
REQ-034 SHALL be verified by this scenario: data block with FSM in RX_C -> 0xFEFEFEFE/F twice, o_decoding_err pulse, FSM=RX_E; next idle block -> RX_C.
REQ-035 SHALL be verified by this scenario: hdr 2'b11 mid-frame -> error words plus pulse; valid gaps between W0 and W1 -> correct decode delayed, no extra outputs.
REQ-036 SHALL be verified by this scenario: reset asserted after W0 only -> no output; next W0/W1 pair decodes normally with latency N+1/N+2.
